// File: rtl/conc_obs_pkg.sv
// Shared definitions for the concolic observation capture stage:
// controller state encoding, trace-record field layout and drop limit.
package conc_obs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Trace record layout: {stamp, cts, ctr, v_out}
  localparam int REC_VOUT_LSB  = 0;
  localparam int REC_VOUT_W    = 4;
  localparam int REC_CTR       = 4;
  localparam int REC_CTS       = 5;
  localparam int REC_STAMP_LSB = 6;

  localparam logic [7:0] DROP_MAX = 8'd255;

  // Saturating increment for the drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == DROP_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/conc_obs_capture_if.sv
// Trace read port: valid/ready drain of packed observation records.
// master = record producer (capture block), slave = trace logger.
interface conc_obs_capture_if #(
  parameter int STAMP_W = 16
);
  import conc_obs_pkg::*;

  localparam int REC_W = STAMP_W + REC_STAMP_LSB;

  logic             rd_valid;
  logic             rd_ready;
  logic [REC_W-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);

endinterface

// File: rtl/conc_obs_fifo.sv
// First-word-fall-through FIFO. The head entry is kept in an output
// register so rd_data is valid the cycle after a push into an empty
// FIFO and holds its last value while empty. Push and pop in the same
// cycle are allowed even when full. flush empties the FIFO and cancels
// any same-cycle push or pop.
module conc_obs_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 22
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] head_next;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LVL_FULL);
  assign level   = count;
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  // Select the record that will sit in the head register after this edge.
  always_comb begin
    head_next = rd_data;
    if (do_pop && (count > LVL_ONE)) begin
      head_next = mem[rd_ptr + PTR_ONE];
    end else if (do_push && (empty || (do_pop && (count == LVL_ONE)))) begin
      head_next = push_data;
    end
  end

  // Storage array write port (no reset: contents are qualified by count).
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_ONE;
        2'b01:   count <= count - LVL_ONE;
        default: count <= count;
      endcase
      rd_data <= head_next;
    end
  end

endmodule

// File: rtl/conc_obs_capture.sv
// Observation stage for the b10 concolic harness: samples {cts,ctr,v_out}
// on observe cycles while running, stamps each sample with the cycle count
// since arm, and buffers the records for a valid/ready trace drain.
// Tracks lost samples with a sticky overflow flag and a saturating counter.
module conc_obs_capture
  import conc_obs_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int STAMP_W      = 16,
  parameter int CHANGE_ONLY  = 0,
  parameter int STOP_ON_FULL = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   arm,
  input  logic                   stop,
  input  logic                   clear,
  input  logic                   obs,
  input  logic                   cts,
  input  logic                   ctr,
  input  logic [3:0]             v_out,
  conc_obs_capture_if.master     rd,
  output logic [$clog2(DEPTH):0] level,
  output logic [1:0]             state,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

  localparam int REC_W = STAMP_W + REC_STAMP_LSB;

  state_t             state_reg, state_next;
  logic [STAMP_W-1:0] stamp_reg, stamp_next;
  logic               first_reg, first_next;
  logic [5:0]         last_reg, last_next;
  logic               overflow_reg, overflow_next;
  logic [7:0]         drop_reg, drop_next;

  logic [5:0]         sample;
  logic [REC_W-1:0]   record;
  logic               candidate;
  logic               room;
  logic               push;
  logic               pop;
  logic               flush;
  logic               fifo_full;
  logic               fifo_empty;

  assign sample    = {cts, ctr, v_out};
  assign candidate = obs && ((CHANGE_ONLY == 0) || first_reg || (sample != last_reg));
  assign pop       = rd.rd_valid && rd.rd_ready;
  assign room      = !fifo_full || pop;

  assign rd.rd_valid = !fifo_empty;
  assign state       = state_reg;
  assign overflow    = overflow_reg;
  assign drop_cnt    = drop_reg;

  // Pack the current sample and stamp into a trace record.
  always_comb begin
    record = '0;
    record[REC_VOUT_LSB +: REC_VOUT_W] = v_out;
    record[REC_CTR]                    = ctr;
    record[REC_CTS]                    = cts;
    record[REC_STAMP_LSB +: STAMP_W]   = stamp_reg;
  end

  // Control FSM next state, capture decision and overflow accounting.
  always_comb begin
    state_next    = state_reg;
    stamp_next    = stamp_reg;
    first_next    = first_reg;
    last_next     = last_reg;
    overflow_next = overflow_reg;
    drop_next     = drop_reg;
    push          = 1'b0;
    flush         = 1'b0;

    if (clear) begin
      flush         = 1'b1;
      state_next    = ST_IDLE;
      overflow_next = 1'b0;
      drop_next     = '0;
      first_next    = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (arm) begin
            state_next = ST_RUN;
            stamp_next = '0;
            first_next = 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_next = ST_HALT;
          end else begin
            stamp_next = stamp_reg + STAMP_W'(1);
            if (candidate) begin
              if (room) begin
                push       = 1'b1;
                last_next  = sample;
                first_next = 1'b0;
              end else if (STOP_ON_FULL != 0) begin
                // Freeze the stamp at the sample that could not be stored.
                state_next    = ST_HALT;
                overflow_next = 1'b1;
                stamp_next    = stamp_reg;
              end else begin
                overflow_next = 1'b1;
                drop_next     = sat_inc8(drop_reg);
              end
            end
          end
        end
        ST_HALT: begin
          // Only clear or reset leaves HALT; the FIFO keeps draining.
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Controller state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      stamp_reg    <= '0;
      first_reg    <= 1'b1;
      last_reg     <= '0;
      overflow_reg <= 1'b0;
      drop_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      stamp_reg    <= stamp_next;
      first_reg    <= first_next;
      last_reg     <= last_next;
      overflow_reg <= overflow_next;
      drop_reg     <= drop_next;
    end
  end

  conc_obs_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (record),
    .pop       (pop),
    .rd_data   (rd.rd_data),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_conc_obs_capture.sv
// Testbench for conc_obs_capture. Three instances share the stimulus:
// dut0 (default), dut1 (CHANGE_ONLY=1), dut2 (STOP_ON_FULL=1), each with
// its own rd_ready. A queue-based reference model tracks all three.
module tb_conc_obs_capture;

  localparam int DEPTH   = 8;
  localparam int STAMP_W = 16;
  localparam int REC_W   = STAMP_W + 6;
  localparam int NDUT    = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, arm, stop, clear, obs, cts, ctr;
  logic [3:0] v_out;
  logic       rr      [NDUT];
  logic       w_valid [NDUT];
  logic [REC_W-1:0] w_data [NDUT];
  logic [3:0] w_level [NDUT];
  logic [1:0] w_state [NDUT];
  logic       w_ovf   [NDUT];
  logic [7:0] w_drop  [NDUT];

  conc_obs_capture_if #(.STAMP_W(STAMP_W)) if0 ();
  conc_obs_capture_if #(.STAMP_W(STAMP_W)) if1 ();
  conc_obs_capture_if #(.STAMP_W(STAMP_W)) if2 ();

  assign if0.rd_ready = rr[0];
  assign if1.rd_ready = rr[1];
  assign if2.rd_ready = rr[2];
  assign w_valid[0] = if0.rd_valid;
  assign w_valid[1] = if1.rd_valid;
  assign w_valid[2] = if2.rd_valid;
  assign w_data[0]  = if0.rd_data;
  assign w_data[1]  = if1.rd_data;
  assign w_data[2]  = if2.rd_data;

  conc_obs_capture #(.DEPTH(DEPTH), .STAMP_W(STAMP_W), .CHANGE_ONLY(0), .STOP_ON_FULL(0)) u0 (
    .clock(clock), .reset(reset), .arm(arm), .stop(stop), .clear(clear), .obs(obs),
    .cts(cts), .ctr(ctr), .v_out(v_out), .rd(if0.master),
    .level(w_level[0]), .state(w_state[0]), .overflow(w_ovf[0]), .drop_cnt(w_drop[0]));

  conc_obs_capture #(.DEPTH(DEPTH), .STAMP_W(STAMP_W), .CHANGE_ONLY(1), .STOP_ON_FULL(0)) u1 (
    .clock(clock), .reset(reset), .arm(arm), .stop(stop), .clear(clear), .obs(obs),
    .cts(cts), .ctr(ctr), .v_out(v_out), .rd(if1.master),
    .level(w_level[1]), .state(w_state[1]), .overflow(w_ovf[1]), .drop_cnt(w_drop[1]));

  conc_obs_capture #(.DEPTH(DEPTH), .STAMP_W(STAMP_W), .CHANGE_ONLY(0), .STOP_ON_FULL(1)) u2 (
    .clock(clock), .reset(reset), .arm(arm), .stop(stop), .clear(clear), .obs(obs),
    .cts(cts), .ctr(ctr), .v_out(v_out), .rd(if2.master),
    .level(w_level[2]), .state(w_state[2]), .overflow(w_ovf[2]), .drop_cnt(w_drop[2]));

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  int         m_state [NDUT];
  int         m_stamp [NDUT];
  int         m_drop  [NDUT];
  bit         m_first [NDUT];
  bit         m_ovf   [NDUT];
  logic [5:0] m_last  [NDUT];
  logic [REC_W-1:0] q0[$];
  logic [REC_W-1:0] q1[$];
  logic [REC_W-1:0] q2[$];

  function automatic int qsize(input int k);
    if (k == 0) return q0.size();
    if (k == 1) return q1.size();
    return q2.size();
  endfunction

  function automatic logic [REC_W-1:0] qfront(input int k);
    if (k == 0) return q0[0];
    if (k == 1) return q1[0];
    return q2[0];
  endfunction

  task automatic qpush(input int k, input logic [REC_W-1:0] v);
    if (k == 0) q0.push_back(v);
    else if (k == 1) q1.push_back(v);
    else q2.push_back(v);
  endtask

  task automatic qpop(input int k);
    if (k == 0) void'(q0.pop_front());
    else if (k == 1) void'(q1.pop_front());
    else void'(q2.pop_front());
  endtask

  task automatic qclear(input int k);
    if (k == 0) q0.delete();
    else if (k == 1) q1.delete();
    else q2.delete();
  endtask

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_state[k] = 0; m_stamp[k] = 0; m_drop[k] = 0;
      m_first[k] = 1'b1; m_ovf[k] = 1'b0; m_last[k] = '0;
      qclear(k);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    for (int k = 0; k < NDUT; k++) begin
      bit         co;
      bit         sof;
      bit         pop;
      int         sz;
      logic [5:0] smp;
      co  = (k == 1);
      sof = (k == 2);
      sz  = qsize(k);
      pop = (sz > 0) && rr[k];
      smp = {cts, ctr, v_out};
      if (clear) begin
        qclear(k);
        m_state[k] = 0; m_ovf[k] = 1'b0; m_drop[k] = 0; m_first[k] = 1'b1;
      end else begin
        if (pop) qpop(k);
        if (m_state[k] == 1 && stop) begin
          m_state[k] = 2;
        end else if (m_state[k] == 0 && arm) begin
          m_state[k] = 1; m_stamp[k] = 0; m_first[k] = 1'b1;
        end else if (m_state[k] == 1) begin
          if (obs && (!co || m_first[k] || smp != m_last[k])) begin
            if (sz < DEPTH || pop) begin
              qpush(k, {16'(m_stamp[k]), smp});
              m_last[k] = smp; m_first[k] = 1'b0;
            end else if (sof) begin
              m_state[k] = 2; m_ovf[k] = 1'b1;
            end else begin
              m_ovf[k] = 1'b1;
              if (m_drop[k] < 255) m_drop[k] = m_drop[k] + 1;
            end
          end
          if (m_state[k] == 1) m_stamp[k] = (m_stamp[k] + 1) % 65536;
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle_in();
    arm = 0; stop = 0; clear = 0; obs = 0; cts = 0; ctr = 0; v_out = 4'd0;
  endtask

  task automatic set_rr(input logic a, input logic b, input logic c);
    rr[0] = a; rr[1] = b; rr[2] = c;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    set_rr(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    for (int k = 0; k < NDUT; k++) begin
      n_checks++; if (w_state[k] !== 2'd0) begin n_fail++; $display("FAIL reset_state dut%0d got %0d want 0", k, w_state[k]); end
      n_checks++; if (w_valid[k] !== 1'b0) begin n_fail++; $display("FAIL reset_valid dut%0d got %b want 0", k, w_valid[k]); end
      n_checks++; if (w_data[k] !== '0) begin n_fail++; $display("FAIL reset_data dut%0d got %h want 0", k, w_data[k]); end
      n_checks++; if (w_level[k] !== 4'd0) begin n_fail++; $display("FAIL reset_level dut%0d got %0d want 0", k, w_level[k]); end
      n_checks++; if (w_ovf[k] !== 1'b0) begin n_fail++; $display("FAIL reset_ovf dut%0d got %b want 0", k, w_ovf[k]); end
      n_checks++; if (w_drop[k] !== 8'd0) begin n_fail++; $display("FAIL reset_drop dut%0d got %0d want 0", k, w_drop[k]); end
    end
  endtask

  task automatic test_basic();
    logic [3:0] vals [3];
    logic [REC_W-1:0] exp;
    vals[0] = 4'd3; vals[1] = 4'd5; vals[2] = 4'd9;
    do_reset();
    set_rr(1'b1, 1'b1, 1'b1);
    arm = 1; tick(); arm = 0;
    obs = 1;
    for (int i = 0; i < 3; i++) begin
      v_out = vals[i];
      tick();
      exp = {16'(i), 1'b0, 1'b0, vals[i]};
      n_checks++; if (w_valid[0] !== 1'b1) begin n_fail++; $display("FAIL basic_valid rec%0d got %b want 1", i, w_valid[0]); end
      n_checks++; if (w_data[0] !== exp) begin n_fail++; $display("FAIL basic_data rec%0d got %h want %h", i, w_data[0], exp); end
    end
    idle_in(); tick();
    n_checks++; if (w_level[0] !== 4'd0) begin n_fail++; $display("FAIL basic_level got %0d want 0", w_level[0]); end
    n_checks++; if (w_valid[0] !== 1'b0) begin n_fail++; $display("FAIL basic_empty got %b want 0", w_valid[0]); end
  endtask

  task automatic test_change_only();
    logic [3:0] vals [5];
    vals[0] = 4'd7; vals[1] = 4'd7; vals[2] = 4'd7; vals[3] = 4'd2; vals[4] = 4'd2;
    do_reset();
    arm = 1; tick(); arm = 0;
    obs = 1;
    for (int i = 0; i < 5; i++) begin v_out = vals[i]; tick(); end
    idle_in();
    n_checks++; if (w_level[1] !== 4'd2) begin n_fail++; $display("FAIL chg_level got %0d want 2", w_level[1]); end
    n_checks++; if (w_data[1] !== {16'd0, 2'b00, 4'd7}) begin n_fail++; $display("FAIL chg_rec0 got %h want %h", w_data[1], {16'd0, 2'b00, 4'd7}); end
    rr[1] = 1; tick();
    n_checks++; if (w_data[1] !== {16'd3, 2'b00, 4'd2}) begin n_fail++; $display("FAIL chg_rec1 got %h want %h", w_data[1], {16'd3, 2'b00, 4'd2}); end
    tick();
    n_checks++; if (w_level[1] !== 4'd0) begin n_fail++; $display("FAIL chg_drained got %0d want 0", w_level[1]); end
  endtask

  task automatic test_overflow();
    logic [5:0] smp [12];
    logic [REC_W-1:0] exp;
    do_reset();
    arm = 1; tick(); arm = 0;
    obs = 1;
    for (int i = 0; i < 12; i++) begin
      cts = 1'($urandom); ctr = 1'($urandom); v_out = 4'($urandom);
      smp[i] = {cts, ctr, v_out};
      tick();
      if (i == 7) begin
        n_checks++; if (w_state[2] !== 2'd1) begin n_fail++; $display("FAIL sof_run8 got %0d want 1", w_state[2]); end
      end
      if (i == 8) begin
        n_checks++; if (w_state[2] !== 2'd2) begin n_fail++; $display("FAIL sof_halt9 got %0d want 2", w_state[2]); end
      end
    end
    idle_in();
    n_checks++; if (w_level[0] !== 4'd8) begin n_fail++; $display("FAIL ovf_level got %0d want 8", w_level[0]); end
    n_checks++; if (w_ovf[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", w_ovf[0]); end
    n_checks++; if (w_drop[0] !== 8'd4) begin n_fail++; $display("FAIL ovf_drop got %0d want 4", w_drop[0]); end
    n_checks++; if (w_state[0] !== 2'd1) begin n_fail++; $display("FAIL ovf_state got %0d want 1", w_state[0]); end
    n_checks++; if (w_level[2] !== 4'd8) begin n_fail++; $display("FAIL sof_level got %0d want 8", w_level[2]); end
    n_checks++; if (w_ovf[2] !== 1'b1) begin n_fail++; $display("FAIL sof_flag got %b want 1", w_ovf[2]); end
    n_checks++; if (w_drop[2] !== 8'd0) begin n_fail++; $display("FAIL sof_drop got %0d want 0", w_drop[2]); end
    rr[0] = 1;
    for (int i = 0; i < 8; i++) begin
      exp = {16'(i), smp[i]};
      n_checks++; if (w_data[0] !== exp) begin n_fail++; $display("FAIL ovf_drain rec%0d got %h want %h", i, w_data[0], exp); end
      tick();
    end
    n_checks++; if (w_level[0] !== 4'd0) begin n_fail++; $display("FAIL ovf_drained got %0d want 0", w_level[0]); end
    arm = 1; tick(); arm = 0;
    n_checks++; if (w_state[2] !== 2'd2) begin n_fail++; $display("FAIL sof_arm_ignored got %0d want 2", w_state[2]); end
    clear = 1; tick(); clear = 0;
    n_checks++; if (w_state[2] !== 2'd0) begin n_fail++; $display("FAIL sof_clear_state got %0d want 0", w_state[2]); end
    n_checks++; if (w_level[2] !== 4'd0) begin n_fail++; $display("FAIL sof_clear_level got %0d want 0", w_level[2]); end
    n_checks++; if (w_ovf[2] !== 1'b0) begin n_fail++; $display("FAIL sof_clear_ovf got %b want 0", w_ovf[2]); end
    n_checks++; if (w_drop[0] !== 8'd0) begin n_fail++; $display("FAIL clear_drop got %0d want 0", w_drop[0]); end
  endtask

  task automatic test_full_push_pop();
    logic [REC_W-1:0] exp;
    do_reset();
    arm = 1; tick(); arm = 0;
    obs = 1;
    for (int i = 0; i < 8; i++) begin v_out = 4'(i); tick(); end
    n_checks++; if (w_level[0] !== 4'd8) begin n_fail++; $display("FAIL fpp_fill got %0d want 8", w_level[0]); end
    rr[0] = 1; v_out = 4'hA; tick();
    obs = 0;
    n_checks++; if (w_level[0] !== 4'd8) begin n_fail++; $display("FAIL fpp_level got %0d want 8", w_level[0]); end
    n_checks++; if (w_drop[0] !== 8'd0) begin n_fail++; $display("FAIL fpp_drop got %0d want 0", w_drop[0]); end
    n_checks++; if (w_ovf[0] !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf got %b want 0", w_ovf[0]); end
    for (int i = 0; i < 8; i++) begin
      exp = {16'(i + 1), 2'b00, (i < 7) ? 4'(i + 1) : 4'hA};
      n_checks++; if (w_data[0] !== exp) begin n_fail++; $display("FAIL fpp_drain rec%0d got %h want %h", i, w_data[0], exp); end
      tick();
    end
  endtask

  task automatic test_stop_obs();
    do_reset();
    rr[0] = 1;
    arm = 1; tick(); arm = 0;
    obs = 1; v_out = 4'd1; tick();
    stop = 1; v_out = 4'd2; tick(); stop = 0;
    n_checks++; if (w_state[0] !== 2'd2) begin n_fail++; $display("FAIL stop_state got %0d want 2", w_state[0]); end
    n_checks++; if (w_level[0] !== 4'd0) begin n_fail++; $display("FAIL stop_level got %0d want 0", w_level[0]); end
    tick();
    n_checks++; if (w_valid[0] !== 1'b0) begin n_fail++; $display("FAIL halt_capture got %b want 0", w_valid[0]); end
    idle_in();
  endtask

  task automatic test_async_reset();
    do_reset();
    arm = 1; tick(); arm = 0;
    obs = 1;
    for (int i = 0; i < 5; i++) begin v_out = 4'(i); tick(); end
    idle_in();
    n_checks++; if (w_level[0] !== 4'd5) begin n_fail++; $display("FAIL arst_pre got %0d want 5", w_level[0]); end
    #3 reset = 1'b1;
    #1;
    n_checks++; if (w_level[0] !== 4'd0) begin n_fail++; $display("FAIL arst_level got %0d want 0", w_level[0]); end
    n_checks++; if (w_valid[0] !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %b want 0", w_valid[0]); end
    n_checks++; if (w_state[0] !== 2'd0) begin n_fail++; $display("FAIL arst_state got %0d want 0", w_state[0]); end
    n_checks++; if (w_data[0] !== '0) begin n_fail++; $display("FAIL arst_data got %h want 0", w_data[0]); end
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      arm   = ($urandom % 6) == 0;
      stop  = ($urandom % 40) == 0;
      clear = ($urandom % 70) == 0;
      obs   = ($urandom % 3) != 0;
      cts   = ($urandom % 4) == 0;
      ctr   = ($urandom % 4) == 0;
      v_out = 4'($urandom % 3);
      for (int k = 0; k < NDUT; k++) rr[k] = ($urandom % 4) < ((c / 75) % 4);
      tick();
      for (int k = 0; k < NDUT; k++) begin
        n_checks++; if (w_state[k] !== 2'(m_state[k])) begin n_fail++; $display("FAIL rnd_state cyc%0d dut%0d got %0d want %0d", c, k, w_state[k], m_state[k]); end
        n_checks++; if (w_level[k] !== 4'(qsize(k))) begin n_fail++; $display("FAIL rnd_level cyc%0d dut%0d got %0d want %0d", c, k, w_level[k], qsize(k)); end
        n_checks++; if (w_valid[k] !== (qsize(k) > 0)) begin n_fail++; $display("FAIL rnd_valid cyc%0d dut%0d got %b want %b", c, k, w_valid[k], qsize(k) > 0); end
        n_checks++; if (w_ovf[k] !== m_ovf[k]) begin n_fail++; $display("FAIL rnd_ovf cyc%0d dut%0d got %b want %b", c, k, w_ovf[k], m_ovf[k]); end
        n_checks++; if (w_drop[k] !== 8'(m_drop[k])) begin n_fail++; $display("FAIL rnd_drop cyc%0d dut%0d got %0d want %0d", c, k, w_drop[k], m_drop[k]); end
        if (qsize(k) > 0) begin
          n_checks++; if (w_data[k] !== qfront(k)) begin n_fail++; $display("FAIL rnd_data cyc%0d dut%0d got %h want %h", c, k, w_data[k], qfront(k)); end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    set_rr(1'b0, 1'b0, 1'b0);
    test_reset();
    test_basic();
    test_change_only();
    test_overflow();
    test_full_push_pop();
    test_stop_obs();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
